// File: rtl/norl_unit_pkg.sv
// Shared constants for the bitwise logic-primitive family (norl, andl, orl, ...).
package norl_unit_pkg;

  localparam int NORL_W_DEFAULT = 8;
  localparam int NORL_W_MAX     = 64;

endpackage

// File: rtl/norl_unit_if.sv
// Operand/result bundle for the NOR unit; the unit sits on the slave side.
interface norl_unit_if
  import norl_unit_pkg::*;
#(
  parameter int WIDTH = NORL_W_DEFAULT
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_q_vld;

  modport master (
    output a, b, en,
    input  y, y_q, y_q_vld
  );

  modport slave (
    input  a, b, en,
    output y, y_q, y_q_vld
  );
endinterface

// File: rtl/norl_unit_nor_cell.sv
// Single-bit NOR gate; plain operators so unknowns propagate unmasked.
module nor_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = ~(i_a | i_b);
endmodule

// File: rtl/norl_unit.sv
// Bitwise NOR with a zero-latency combinational result and an enabled capture register.
module norl_unit
  import norl_unit_pkg::*;
#(
  parameter int WIDTH = NORL_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  norl_unit_if.slave  bus
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_y_q_vld;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    nor_cell u_cell (
      .i_a (bus.a[i]),
      .i_b (bus.b[i]),
      .o_y (w_y[i])
    );
  end

  // Reset takes priority over a same-edge capture request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q     <= '0;
      r_y_q_vld <= 1'b0;
    end else if (bus.en) begin
      r_y_q     <= w_y;
      r_y_q_vld <= 1'b1;
    end
  end

  assign bus.y       = w_y;
  assign bus.y_q     = r_y_q;
  assign bus.y_q_vld = r_y_q_vld;

endmodule

// File: tb/tb_norl_unit.sv
// Self-checking bench for norl_unit: directed vectors plus randomized capture traffic.
module tb_norl_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [W-1:0] exp_q;
  logic         exp_vld;

  norl_unit_if #(.WIDTH(W)) bus ();

  norl_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Per-bit NOR truth table with explicit unknown handling.
  function automatic logic [W-1:0] nor_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      if (a[i] === 1'b1 || b[i] === 1'b1)      r[i] = 1'b0;
      else if (a[i] === 1'b0 && b[i] === 1'b0) r[i] = 1'b1;
      else                                     r[i] = 1'bx;
    end
    return r;
  endfunction

  // Advance one edge, updating the register model from the inputs present at that edge.
  task automatic tick();
    if (rst) begin
      exp_q   = '0;
      exp_vld = 1'b0;
    end else if (bus.en) begin
      exp_q   = nor_ref(bus.a, bus.b);
      exp_vld = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.a = '0; bus.b = '0;
    tick(); tick();
    checks++;
    if (bus.y_q !== 8'h00) begin errors++; $display("FAIL reset_y_q got=%h want=00", bus.y_q); end
    checks++;
    if (bus.y_q_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b want=0", bus.y_q_vld); end
    rst = 1'b0;
  endtask

  task automatic test_comb();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] vy [4];
    va = '{8'b11110000, 8'b11110000, 8'b11110000, 8'b00000000};
    vb = '{8'b00000000, 8'b11111111, 8'b10101010, 8'b00000000};
    vy = '{8'b00001111, 8'b00000000, 8'b00000101, 8'b11111111};
    for (int k = 0; k < 4; k++) begin
      bus.a = va[k]; bus.b = vb[k];
      #1;
      checks++;
      if (bus.y !== vy[k]) begin
        errors++; $display("FAIL comb_vec%0d got=%b want=%b", k, bus.y, vy[k]);
      end
    end
    for (int k = 0; k < 16; k++) begin
      bus.a = W'($urandom); bus.b = W'($urandom);
      #1;
      checks++;
      if (bus.y !== nor_ref(bus.a, bus.b)) begin
        errors++; $display("FAIL comb_rand got=%b want=%b", bus.y, nor_ref(bus.a, bus.b));
      end
    end
  endtask

  task automatic test_xprop();
    bus.en = 1'b0;
    bus.a = 8'bxxxxxxxx; bus.b = 8'bxxxxxxxx;
    #1;
    checks++;
    if (bus.y !== nor_ref(bus.a, bus.b)) begin
      errors++; $display("FAIL xprop_allx got=%b want=%b", bus.y, nor_ref(bus.a, bus.b));
    end
    bus.a = 8'b1111xxxx; bus.b = 8'bxxxx0000;
    #1;
    checks++;
    if (bus.y[7:4] !== 4'b0000) begin
      errors++; $display("FAIL xprop_dominant got=%b want=0000", bus.y[7:4]);
    end
    checks++;
    if (bus.y !== nor_ref(bus.a, bus.b)) begin
      errors++; $display("FAIL xprop_mixed got=%b want=%b", bus.y, nor_ref(bus.a, bus.b));
    end
    bus.a = '0; bus.b = '0;
  endtask

  task automatic test_capture();
    bus.a = 8'hF0; bus.b = 8'hAA; bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    checks++;
    if (bus.y_q !== 8'h05) begin errors++; $display("FAIL capture_y_q got=%h want=05", bus.y_q); end
    checks++;
    if (bus.y_q_vld !== 1'b1) begin errors++; $display("FAIL capture_vld got=%b want=1", bus.y_q_vld); end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 4; k++) begin
      bus.a = W'($urandom); bus.b = W'($urandom);
      tick();
      bus.a = W'($urandom); bus.b = W'($urandom);
      #2;
      checks++;
      if (bus.y_q !== 8'h05 || bus.y_q_vld !== 1'b1) begin
        errors++; $display("FAIL hold_y_q got=%h/%b want=05/1", bus.y_q, bus.y_q_vld);
      end
      checks++;
      if (bus.y !== ~(bus.a | bus.b)) begin
        errors++; $display("FAIL hold_y_tracks got=%h want=%h", bus.y, ~(bus.a | bus.b));
      end
    end
  endtask

  task automatic test_reset_wins();
    bus.a = 8'h0F; bus.b = 8'h00; bus.en = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (bus.y_q !== 8'h00 || bus.y_q_vld !== 1'b0) begin
      errors++; $display("FAIL reset_wins got=%h/%b want=00/0", bus.y_q, bus.y_q_vld);
    end
    checks++;
    if (bus.y !== 8'hF0) begin errors++; $display("FAIL reset_y_unaffected got=%h want=f0", bus.y); end
    rst = 1'b0; bus.en = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      bus.a  = W'($urandom);
      bus.b  = W'($urandom);
      bus.en = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (bus.y_q !== exp_q || bus.y_q_vld !== exp_vld) begin
        errors++;
        $display("FAIL b2b_cycle%0d got=%h/%b want=%h/%b", k, bus.y_q, bus.y_q_vld, exp_q, exp_vld);
      end
    end
    rst = 1'b0; bus.en = 1'b0;
  endtask

  initial begin
    exp_q = 'x; exp_vld = 1'bx;
    test_reset();
    test_comb();
    test_xprop();
    test_capture();
    test_hold();
    test_reset_wins();
    test_capture();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
